cam_config_seq: RTL and testbench
=================================

CAM_CONFIG_SEQ -- requirements
Module: cam_config_seq

Interface
REQ-001 Parameter DELAY_CYCLES, default 270000, is the number of i_clk cycles waited for a delay entry (10 ms at 27 MHz).
REQ-002 Parameter LAST_ADDR, default 8'd255, is the highest ROM address scanned before forced completion.
REQ-003 i_clk, input, 1: system clock (27 MHz).
REQ-004 i_rstn, input, 1: asynchronous, active-low reset.
REQ-005 i_start, input, 1: single-cycle request to run the configuration sequence.
REQ-006 o_rom_addr, output, 8: configuration ROM address.
REQ-007 i_rom_data, input, 16: ROM word {reg_addr[15:8], reg_data[7:0]}, valid one cycle after o_rom_addr changes.
REQ-008 o_sccb_valid, output, 1: SCCB write request.
REQ-009 o_sccb_addr, output, 8: SCCB register address.
REQ-010 o_sccb_data, output, 8: SCCB register data.
REQ-011 i_sccb_ready, input, 1: SCCB master accepts the request in any cycle where it and o_sccb_valid are both high.
REQ-012 i_sccb_done, input, 1: single-cycle pulse when an accepted write completes on the bus.
REQ-013 o_busy, output, 1: sequence in progress.
REQ-014 o_done, output, 1: sequence complete; level, held until the next start or reset.

Function
REQ-015 The FSM shall have the states IDLE, FETCH, DECODE, SEND, WAIT_DONE, DELAY and FINISH.
REQ-016 In IDLE or FINISH, i_start=1 shall set o_rom_addr to 0, clear o_done, set o_busy and go to FETCH.
REQ-017 FETCH shall last exactly one cycle to cover ROM latency, then go to DECODE.
REQ-018 DECODE shall sample i_rom_data and select the next state.
  - 16'hFFFF: go to FINISH.
  - 16'hFFF0: load the delay counter with DELAY_CYCLES-1 and go to DELAY.
  - Any other value: register the word into o_sccb_addr and o_sccb_data and go to SEND.
REQ-019 SEND shall hold o_sccb_valid=1 with stable addr/data until i_sccb_ready=1, then deassert o_sccb_valid the next cycle and go to WAIT_DONE.
REQ-020 o_sccb_valid shall be 1 only in SEND, and never for FFFF or FFF0 entries.
REQ-021 WAIT_DONE shall hold until i_sccb_done=1, then advance.
REQ-022 DELAY shall decrement the counter every cycle and advance when it reaches 0, so it occupies exactly DELAY_CYCLES cycles.
REQ-023 Advance means:
  - If o_rom_addr == LAST_ADDR: go to FINISH.
  - Otherwise: increment o_rom_addr by 1 and go to FETCH. The address never wraps to 0.
REQ-024 FINISH shall set o_done=1 and o_busy=0 and hold o_rom_addr.
REQ-025 i_start shall be ignored while o_busy=1.
REQ-026 i_sccb_done outside WAIT_DONE shall be ignored.
REQ-027 i_sccb_done arriving in the same cycle as acceptance in SEND shall not be lost; the FSM shall skip WAIT_DONE and advance directly.
REQ-028 Latency: with an i_start pulse sampled at edge N and a normal entry at address 0, o_sccb_valid shall be high from edge N+3.
REQ-029 The delay counter shall be wide enough for DELAY_CYCLES (19 bits at the default).

Reset
REQ-030 While i_rstn=0, asynchronously: state=IDLE, o_rom_addr=0, o_sccb_valid=0, o_sccb_addr=0, o_sccb_data=0, o_busy=0, o_done=0, delay counter=0.
REQ-031 Reset asserted mid-sequence, including in DELAY or WAIT_DONE, shall abort it; after release the block shall wait in IDLE for a new i_start.
REQ-032 The block shall not start automatically after reset.

Verification
REQ-033 ROM {0:1280, 1:FFF0, 2:1214, 3:FFFF}, DELAY_CYCLES=100, ready tied high, done 5 cycles after accept -> two writes (12/80 then 12/14); the second write's valid rises 100 cycles after DELAY entry plus 3 cycles; o_done=1 with o_rom_addr=3.
REQ-034 i_sccb_ready held low 20 cycles in SEND -> o_sccb_valid and addr/data stay stable for all 20 cycles; exactly one accept occurs.
REQ-035 i_start pulsed mid-sequence, and i_sccb_done pulsed while in DELAY -> no restart and no early advance; write count is unchanged.
REQ-036 ROM with no FFFF entry (all 16'h1100), LAST_ADDR=255 -> exactly 256 writes, then o_done=1 and o_rom_addr=255 with no wrap.
REQ-037 i_rstn pulsed low during DELAY -> all outputs return to reset values immediately; nothing happens until i_start; a rerun completes normally.
REQ-038 i_sccb_done asserted in the same cycle as acceptance -> the next FETCH occurs without a WAIT_DONE stall.

Source files
------------

// File: rtl/cam_config_seq.sv
// Camera register configuration sequencer. Walks a config ROM and issues SCCB writes.
// Ports: i_clk/i_rstn, i_start, ROM (o_rom_addr, i_rom_data), SCCB (o_sccb_*, i_sccb_*), o_busy, o_done.
module cam_config_seq #(
  parameter int         DELAY_CYCLES = 270000,
  parameter logic [7:0] LAST_ADDR    = 8'd255
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_start,
  output logic [7:0]  o_rom_addr,
  input  logic [15:0] i_rom_data,
  output logic        o_sccb_valid,
  output logic [7:0]  o_sccb_addr,
  output logic [7:0]  o_sccb_data,
  input  logic        i_sccb_ready,
  input  logic        i_sccb_done,
  output logic        o_busy,
  output logic        o_done
);

  localparam int CW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_SEND,
    S_WAIT_DONE,
    S_DELAY,
    S_FINISH
  } state_t;

  state_t        r_state;
  logic [7:0]    r_rom_addr;
  logic          r_valid;
  logic [7:0]    r_sccb_addr;
  logic [7:0]    r_sccb_data;
  logic          r_busy;
  logic          r_done;
  logic [CW-1:0] r_dcnt;

  logic w_end;
  logic w_dly;
  logic w_last;
  logic w_accept;
  logic w_adv;

  assign w_end    = (i_rom_data == 16'hFFFF);
  assign w_dly    = (i_rom_data == 16'hFFF0);
  assign w_last   = (r_rom_addr == LAST_ADDR);
  assign w_accept = (r_state == S_SEND) && r_valid && i_sccb_ready;

  // A done pulse coinciding with acceptance completes the entry at once.
  assign w_adv = (w_accept && i_sccb_done)
              || ((r_state == S_WAIT_DONE) && i_sccb_done)
              || ((r_state == S_DELAY) && (r_dcnt == '0));

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state     <= S_IDLE;
      r_rom_addr  <= 8'd0;
      r_valid     <= 1'b0;
      r_sccb_addr <= 8'd0;
      r_sccb_data <= 8'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_dcnt      <= '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_FINISH: begin
          if (i_start) begin
            r_rom_addr <= 8'd0;
            r_done     <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          unique case (1'b1)
            w_end: begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_FINISH;
            end
            w_dly: begin
              r_dcnt  <= CW'(DELAY_CYCLES - 1);
              r_state <= S_DELAY;
            end
            default: begin
              r_sccb_addr <= i_rom_data[15:8];
              r_sccb_data <= i_rom_data[7:0];
              r_state     <= S_SEND;
            end
          endcase
        end
        S_SEND: begin
          // First SEND cycle raises valid; it drops on acceptance.
          if (!r_valid) begin
            r_valid <= 1'b1;
          end else if (i_sccb_ready) begin
            r_valid <= 1'b0;
            r_state <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          r_state <= S_WAIT_DONE;
        end
        S_DELAY: begin
          if (r_dcnt != '0) begin
            r_dcnt <= r_dcnt - 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      // Step to the next ROM entry, stopping at the last address.
      if (w_adv) begin
        if (w_last) begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_FINISH;
        end else begin
          r_rom_addr <= r_rom_addr + 8'd1;
          r_state    <= S_FETCH;
        end
      end
    end
  end

  assign o_rom_addr   = r_rom_addr;
  assign o_sccb_valid = r_valid;
  assign o_sccb_addr  = r_sccb_addr;
  assign o_sccb_data  = r_sccb_data;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule

// File: tb/tb_cam_config_seq.sv
// Testbench for cam_config_seq: ROM model, SCCB slave model, write scoreboard.
// Directed steps in one initial block; writes checked at acceptance.
module tb_cam_config_seq;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [7:0]  rom_addr;
  logic [15:0] rom_q;
  logic        valid;
  logic [7:0]  sa;
  logic [7:0]  sd;
  logic        ready;
  logic        done_s;
  logic        done_x;
  logic        sccb_done;
  logic        busy;
  logic        done;

  logic [15:0] rom [256];
  logic [15:0] exp_q [$];
  logic [15:0] exp_w;

  int total = 0;
  int bad = 0;
  int acc = 0;
  int done_cnt = 0;
  int done_lat = 5;
  bit same_done = 1'b0;
  int a0;
  int ok;

  assign sccb_done = done_s | done_x;

  cam_config_seq #(
    .DELAY_CYCLES(100),
    .LAST_ADDR   (8'd255)
  ) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_start     (start),
    .o_rom_addr  (rom_addr),
    .i_rom_data  (rom_q),
    .o_sccb_valid(valid),
    .o_sccb_addr (sa),
    .o_sccb_data (sd),
    .i_sccb_ready(ready),
    .i_sccb_done (sccb_done),
    .o_busy      (busy),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_q <= rom[rom_addr];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // SCCB slave: accepts when valid&ready, pulses done later or same cycle.
  always @(negedge clk) begin
    #1;
    done_s = 1'b0;
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) done_s = 1'b1;
    end
    if (rstn && valid && ready) begin
      acc++;
      if (exp_q.size() == 0) begin
        chk("sb_extra", 32'(exp_q.size()), 32'd1);
      end else begin
        exp_w = exp_q.pop_front();
        chk("sb_wr", {16'h0, sa, sd}, {16'h0, exp_w});
      end
      if (same_done) done_s = 1'b1;
      else done_cnt = done_lat;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic fill(input logic [15:0] v);
    for (int i = 0; i < 256; i++) rom[i] = v;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int n;
    n = 0;
    while (valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(valid), 32'd1);
  endtask

  initial begin
    rstn   = 1'b0;
    start  = 1'b0;
    ready  = 1'b1;
    done_x = 1'b0;
    fill(16'hFFFF);

    // Reset values and no auto-start
    #7;
    chk("rst_vals", {5'd0, rom_addr, busy, done, valid, sa, sd}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    tick(10);
    chk("no_autostart", {busy, done, valid}, 3'b000);

    // Basic sequence with delay entry
    fill(16'hFFFF);
    rom[0] = 16'h1280;
    rom[1] = 16'hFFF0;
    rom[2] = 16'h1214;
    rom[3] = 16'hFFFF;
    exp_q.push_back(16'h1280);
    exp_q.push_back(16'h1214);
    ready = 1'b1;
    same_done = 1'b0;
    a0 = acc;
    pulse_start();
    tick(2);
    chk("lat_pre", 32'(valid), 32'd0);
    chk("busy_run", 32'(busy), 32'd1);
    tick(1);
    chk("lat_valid", 32'(valid), 32'd1);
    chk("lat_word", {sa, sd}, 16'h1280);
    tick(110);
    chk("dly_pre", 32'(valid), 32'd0);
    tick(1);
    chk("dly_valid", 32'(valid), 32'd1);
    chk("dly_word", {sa, sd}, 16'h1214);
    wait_done(200, "a_done");
    chk("a_addr", 32'(rom_addr), 32'd3);
    chk("a_busy", 32'(busy), 32'd0);
    chk("a_writes", 32'(acc - a0), 32'd2);

    // Ready held low: request must stay stable
    fill(16'hFFFF);
    rom[0] = 16'h3456;
    exp_q.push_back(16'h3456);
    ready = 1'b0;
    a0 = acc;
    pulse_start();
    chk("done_clr", 32'(done), 32'd0);
    wait_valid(10, "b_valid");
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (valid === 1'b1 && {sa, sd} === 16'h3456) ok++;
      tick(1);
    end
    chk("b_stable", 32'(ok), 32'd20);
    ready = 1'b1;
    wait_done(50, "b_done");
    chk("b_writes", 32'(acc - a0), 32'd1);

    // Stray start and done while delaying
    fill(16'hFFFF);
    rom[0] = 16'h1111;
    rom[1] = 16'hFFF0;
    rom[2] = 16'h2222;
    rom[3] = 16'hFFFF;
    exp_q.push_back(16'h1111);
    exp_q.push_back(16'h2222);
    a0 = acc;
    pulse_start();
    tick(19);
    start = 1'b1;
    done_x = 1'b1;
    tick(1);
    start = 1'b0;
    done_x = 1'b0;
    tick(30);
    chk("c_writes_mid", 32'(acc - a0), 32'd1);
    chk("c_addr_mid", 32'(rom_addr), 32'd1);
    chk("c_busy_mid", 32'(busy), 32'd1);
    tick(63);
    chk("c_dly_pre", 32'(valid), 32'd0);
    tick(1);
    chk("c_dly_valid", 32'(valid), 32'd1);
    wait_done(200, "c_done");
    chk("c_addr", 32'(rom_addr), 32'd3);
    chk("c_writes", 32'(acc - a0), 32'd2);

    // Done coincident with acceptance skips the wait
    fill(16'hFFFF);
    rom[0] = 16'h0101;
    rom[1] = 16'h0202;
    exp_q.push_back(16'h0101);
    exp_q.push_back(16'h0202);
    same_done = 1'b1;
    a0 = acc;
    pulse_start();
    tick(4);
    chk("d_addr_fast", 32'(rom_addr), 32'd1);
    tick(3);
    chk("d_valid2", 32'(valid), 32'd1);
    chk("d_word2", {sa, sd}, 16'h0202);
    wait_done(50, "d_done");
    chk("d_addr", 32'(rom_addr), 32'd2);
    chk("d_writes", 32'(acc - a0), 32'd2);

    // Reset during delay aborts, then a rerun
    same_done = 1'b0;
    fill(16'hFFFF);
    rom[0] = 16'h0A0B;
    rom[1] = 16'hFFF0;
    rom[2] = 16'h0C0D;
    rom[3] = 16'hFFFF;
    exp_q.push_back(16'h0A0B);
    a0 = acc;
    pulse_start();
    tick(30);
    chk("e_in_dly", 32'(rom_addr), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("e_rst_async",
        {5'd0, rom_addr, busy, done, valid, sa, sd}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    tick(150);
    chk("e_idle", {busy, done, valid}, 3'b000);
    chk("e_writes_idle", 32'(acc - a0), 32'd1);
    exp_q.push_back(16'h0A0B);
    exp_q.push_back(16'h0C0D);
    pulse_start();
    wait_done(300, "e_done");
    chk("e_addr", 32'(rom_addr), 32'd3);
    chk("e_writes", 32'(acc - a0), 32'd3);

    // No end marker: full scan, no wrap
    same_done = 1'b1;
    fill(16'h1100);
    for (int i = 0; i < 256; i++) exp_q.push_back(16'h1100);
    a0 = acc;
    pulse_start();
    wait_done(3000, "f_done");
    chk("f_writes", 32'(acc - a0), 32'd256);
    chk("f_addr", 32'(rom_addr), 32'd255);
    tick(10);
    chk("f_nowrap", {rom_addr, valid, done}, {8'd255, 1'b0, 1'b1});

    chk("q_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
